// File: rtl/sdio_pkg.sv
// Shared definitions for the SD host command path: FSM states, response types
// and the stop-transmission command index.
package sdio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RSP  = 2'd2,
    ST_WAIT_BUSY = 2'd3
  } cmd_state_e;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_R48  = 2'b01;
  localparam logic [1:0] RSP_R136 = 2'b10;
  localparam logic [1:0] RSP_R48B = 2'b11;

  localparam int unsigned CMD12_IDX = 12;

endpackage

// File: rtl/sdio_cmd_timer.sv
// Saturating cycle counter with synchronous clear and a limit comparator;
// a zero limit disables the hit output.
module sdio_cmd_timer #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 hit
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  assign hit = (limit != '0) && (cnt_q >= limit);

endmodule

// File: rtl/sdio_cmd_sched.sv
// SD command scheduler: arbitrates host commands against the automatic CMD12,
// issues them to the command engine and supervises response/busy timeouts.
// Optional feature macro: SDIO_AUTO_STOP_EN (auto CMD12 after multi-block data).
module sdio_cmd_sched
  import sdio_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned STOP_IDX  = CMD12_IDX
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 cmd_sd_rst,
  input  logic                 host_req,
  input  logic [5:0]           host_idx,
  input  logic [31:0]          host_arg,
  input  logic [1:0]           host_rsp,
  output logic                 host_ack,
  input  logic                 auto_stop_en,
  input  logic                 dat_multi,
  input  logic                 dat_done_event,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 cmd_start,
  output logic [5:0]           cmd_idx,
  output logic [31:0]          cmd_arg,
  output logic [1:0]           cmd_rsp,
  input  logic                 eng_done,
  output logic                 eng_abort,
  input  logic                 dat0_busy,
  output logic                 cmd_done_event,
  output logic                 cmd_timeout_err_event,
  output logic                 busy,
  output logic                 auto_cmd
);

  cmd_state_e state_q, state_d;

  logic stop_req;
  logic grant_stop, grant_host;
  logic tmr_clr, tmr_en, tmr_hit;
  logic start_d, done_d, tout_d;

`ifdef SDIO_AUTO_STOP_EN
  logic stop_set;
  logic stop_pend_q;

  assign stop_set = dat_done_event & auto_stop_en & dat_multi;
  // A stop event arriving in the same cycle as a host request still wins.
  assign stop_req = stop_pend_q | stop_set;

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      stop_pend_q <= 1'b0;
    end else if (cmd_sd_rst || grant_stop) begin
      stop_pend_q <= 1'b0;
    end else if (stop_set) begin
      stop_pend_q <= 1'b1;
    end
  end
`else
  logic unused_auto_stop;

  assign unused_auto_stop = ^{auto_stop_en, dat_multi, dat_done_event};
  assign stop_req         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_stop = 1'b0;
    grant_host = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    tout_d     = 1'b0;
    if (cmd_sd_rst) begin
      state_d = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stop_req) begin
            grant_stop = 1'b1;
            state_d    = ST_ISSUE;
          end else if (host_req) begin
            grant_host = 1'b1;
            state_d    = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start_d = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_WAIT_RSP;
        end
        ST_WAIT_RSP: begin
          tmr_en = 1'b1;
          // Completion is checked first so it masks a coincident timeout.
          if (eng_done) begin
            if (cmd_rsp == RSP_R48B) begin
              tmr_clr = 1'b1;
              state_d = ST_WAIT_BUSY;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (tmr_hit) begin
            tout_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_BUSY: begin
          tmr_en = 1'b1;
          if (!dat0_busy) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (tmr_hit) begin
            tout_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  sdio_cmd_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .sd_clk(sd_clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (timeout_limit),
    .hit   (tmr_hit)
  );

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q               <= ST_IDLE;
      host_ack              <= 1'b0;
      cmd_start             <= 1'b0;
      cmd_done_event        <= 1'b0;
      cmd_timeout_err_event <= 1'b0;
      eng_abort             <= 1'b0;
      busy                  <= 1'b0;
      cmd_idx               <= '0;
      cmd_arg               <= '0;
      cmd_rsp               <= '0;
    end else begin
      state_q               <= state_d;
      host_ack              <= grant_host;
      cmd_start             <= start_d;
      cmd_done_event        <= done_d;
      cmd_timeout_err_event <= tout_d;
      eng_abort             <= tout_d;
      busy                  <= (state_d != ST_IDLE);
      if (grant_stop) begin
        cmd_idx <= 6'(STOP_IDX);
        cmd_arg <= '0;
        cmd_rsp <= RSP_R48B;
      end else if (grant_host) begin
        cmd_idx <= host_idx;
        cmd_arg <= host_arg;
        cmd_rsp <= host_rsp;
      end
    end
  end

`ifdef SDIO_AUTO_STOP_EN
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      auto_cmd <= 1'b0;
    end else if (grant_stop) begin
      auto_cmd <= 1'b1;
    end else if (grant_host) begin
      auto_cmd <= 1'b0;
    end
  end
`else
  assign auto_cmd = 1'b0;
`endif

endmodule

// File: tb/tb_sdio_cmd_sched.sv
// Directed self-checking bench for sdio_cmd_sched with a command scoreboard.
module tb_sdio_cmd_sched;
  import sdio_pkg::*;

  localparam int unsigned TW = 16;

  typedef struct packed {
    logic        auto_c;
    logic [1:0]  rsp;
    logic [5:0]  idx;
    logic [31:0] arg;
  } exp_t;

  logic          sd_clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_sd_rst = 1'b0;
  logic          host_req = 1'b0;
  logic [5:0]    host_idx = '0;
  logic [31:0]   host_arg = '0;
  logic [1:0]    host_rsp = '0;
  logic          host_ack;
  logic          auto_stop_en = 1'b0;
  logic          dat_multi = 1'b0;
  logic          dat_done_event = 1'b0;
  logic [TW-1:0] timeout_limit = '0;
  logic          cmd_start;
  logic [5:0]    cmd_idx;
  logic [31:0]   cmd_arg;
  logic [1:0]    cmd_rsp;
  logic          eng_done = 1'b0;
  logic          eng_abort;
  logic          dat0_busy = 1'b0;
  logic          cmd_done_event;
  logic          cmd_timeout_err_event;
  logic          busy;
  logic          auto_cmd;

  int n_cmp = 0;
  int n_err = 0;
  int n_ack = 0, n_start = 0, n_done = 0, n_tout = 0, n_abort = 0;
  int snap;
  exp_t sb[$];

  always #5 sd_clk = ~sd_clk;

  sdio_cmd_sched #(
    .TIMEOUT_W(TW),
    .STOP_IDX (12)
  ) dut (
    .sd_clk               (sd_clk),
    .rst                  (rst),
    .cmd_sd_rst           (cmd_sd_rst),
    .host_req             (host_req),
    .host_idx             (host_idx),
    .host_arg             (host_arg),
    .host_rsp             (host_rsp),
    .host_ack             (host_ack),
    .auto_stop_en         (auto_stop_en),
    .dat_multi            (dat_multi),
    .dat_done_event       (dat_done_event),
    .timeout_limit        (timeout_limit),
    .cmd_start            (cmd_start),
    .cmd_idx              (cmd_idx),
    .cmd_arg              (cmd_arg),
    .cmd_rsp              (cmd_rsp),
    .eng_done             (eng_done),
    .eng_abort            (eng_abort),
    .dat0_busy            (dat0_busy),
    .cmd_done_event       (cmd_done_event),
    .cmd_timeout_err_event(cmd_timeout_err_event),
    .busy                 (busy),
    .auto_cmd             (auto_cmd)
  );

  always @(negedge sd_clk) begin
    if (!rst) begin
      if (host_ack === 1'b1)              n_ack++;
      if (cmd_start === 1'b1)             n_start++;
      if (cmd_done_event === 1'b1)        n_done++;
      if (cmd_timeout_err_event === 1'b1) n_tout++;
      if (eng_abort === 1'b1)             n_abort++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, observed hang, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_check(input string tag);
    exp_t e;
    check({tag, "_start"}, 64'(cmd_start), 64'd1);
    check({tag, "_sb_avail"}, 64'(sb.size() > 0), 64'd1);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_cmd"}, 64'({auto_cmd, cmd_rsp, cmd_idx, cmd_arg}), 64'(e));
  endtask

  task automatic host_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] rsp);
    host_idx = idx;
    host_arg = arg;
    host_rsp = rsp;
    host_req = 1'b1;
    sb.push_back('{auto_c: 1'b0, rsp: rsp, idx: idx, arg: arg});
    tick();
    check({tag, "_ack"}, 64'({host_ack, busy}), 64'b11);
    host_req = 1'b0;
    tick();
    check({tag, "_ack_single"}, 64'(host_ack), 64'd0);
    start_check(tag);
  endtask

  task automatic eng_pulse();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_outs", 64'({host_ack, cmd_start, eng_abort, cmd_done_event,
                           cmd_timeout_err_event, busy, auto_cmd}), 64'd0);
    check("rst_cmd", 64'({cmd_idx, cmd_arg, cmd_rsp}), 64'd0);
    rst = 1'b0;
    tick();

    // Host R48 command, completion one cycle after eng_done
    host_cmd("t1", 6'd17, 32'h1234, RSP_R48);
    repeat (19) tick();
    eng_pulse();
    check("t1_done", 64'({cmd_done_event, busy}), 64'b10);
    check("t1_idx", 64'(cmd_idx), 64'd17);
    tick();
    check("t1_done_single", 64'(cmd_done_event), 64'd0);

    // R48 with busy: completion follows dat0 release
    host_cmd("t2", 6'd7, 32'hDEADBEEF, RSP_R48B);
    repeat (4) tick();
    dat0_busy = 1'b1;
    eng_pulse();
    check("t2_in_busy", 64'({cmd_done_event, busy}), 64'b01);
    snap = n_done;
    repeat (50) tick();
    check("t2_hold", 64'(n_done - snap), 64'd0);
    dat0_busy = 1'b0;
    tick();
    check("t2_done", 64'({cmd_done_event, busy}), 64'b10);

    // Response timeout, limit 8 -> 9 cycles after cmd_start
    timeout_limit = 16'd8;
    host_cmd("t3", 6'd2, 32'h0, RSP_R48);
    repeat (8) tick();
    check("t3_early", 64'({cmd_timeout_err_event, eng_abort}), 64'b00);
    tick();
    check("t3_tout", 64'({cmd_timeout_err_event, eng_abort, cmd_done_event, busy}), 64'b1100);
    tick();
    check("t3_tout_single", 64'(cmd_timeout_err_event), 64'd0);

    // Limit 0 waits indefinitely
    timeout_limit = '0;
    snap = n_tout;
    host_cmd("t4", 6'd3, 32'h55, RSP_R136);
    repeat (40) tick();
    check("t4_wait", 64'({busy, 8'(n_tout - snap)}), 64'h100);
    eng_pulse();
    check("t4_done", 64'(cmd_done_event), 64'd1);

    // eng_done in the very cycle the limit is reached
    timeout_limit = 16'd8;
    host_cmd("t5", 6'd9, 32'h99, RSP_R48);
    repeat (8) tick();
    eng_pulse();
    check("t5_done_wins", 64'({cmd_done_event, cmd_timeout_err_event, eng_abort}), 64'b100);
    tick();
    check("t5_no_late_tout", 64'(cmd_timeout_err_event), 64'd0);

    // Busy-phase timeout
    host_cmd("t6", 6'd10, 32'hA, RSP_R48B);
    dat0_busy = 1'b1;
    eng_pulse();
    check("t6_in_busy", 64'({cmd_done_event, busy}), 64'b01);
    repeat (8) tick();
    check("t6_early", 64'(cmd_timeout_err_event), 64'd0);
    tick();
    check("t6_tout", 64'({cmd_timeout_err_event, eng_abort, cmd_done_event, busy}), 64'b1100);
    dat0_busy = 1'b0;
    tick();

    // Soft reset in WAIT_BUSY drops the pending stop and emits nothing
    timeout_limit = '0;
    auto_stop_en = 1'b1;
    dat_multi = 1'b1;
    host_cmd("t7", 6'd13, 32'hC0FFEE, RSP_R48B);
    dat0_busy = 1'b1;
    eng_pulse();
    tick();
    dat_done_event = 1'b1;
    tick();
    dat_done_event = 1'b0;
    tick();
    cmd_sd_rst = 1'b1;
    tick();
    cmd_sd_rst = 1'b0;
    check("t7_idle", 64'({busy, cmd_done_event, cmd_timeout_err_event, eng_abort}), 64'd0);
    check("t7_keep", 64'({cmd_idx, cmd_arg, cmd_rsp}), 64'({6'd13, 32'hC0FFEE, RSP_R48B}));
    snap = n_start;
    dat0_busy = 1'b0;
    repeat (5) tick();
    check("t7_no_stop", 64'({busy, 8'(n_start - snap)}), 64'd0);

    // Stop event coinciding with a host request
    host_idx = 6'd18;
    host_arg = 32'h200;
    host_rsp = RSP_R48;
    host_req = 1'b1;
    dat_done_event = 1'b1;
`ifdef SDIO_AUTO_STOP_EN
    sb.push_back('{auto_c: 1'b1, rsp: RSP_R48B, idx: 6'd12, arg: 32'h0});
    sb.push_back('{auto_c: 1'b0, rsp: RSP_R48, idx: 6'd18, arg: 32'h200});
    tick();
    dat_done_event = 1'b0;
    check("t8_stop_grant", 64'({host_ack, auto_cmd, busy}), 64'b011);
    tick();
    start_check("t8_stop");
    repeat (3) tick();
    eng_pulse();
    tick();
    check("t8_stop_done", 64'({cmd_done_event, busy}), 64'b10);
    tick();
    check("t8_host_ack", 64'({host_ack, auto_cmd}), 64'b10);
    host_req = 1'b0;
    tick();
    start_check("t8_host");
`else
    sb.push_back('{auto_c: 1'b0, rsp: RSP_R48, idx: 6'd18, arg: 32'h200});
    tick();
    dat_done_event = 1'b0;
    check("t8_host_ack", 64'({host_ack, auto_cmd}), 64'b10);
    host_req = 1'b0;
    tick();
    start_check("t8_host");
`endif
    repeat (3) tick();
    eng_pulse();
    check("t8_host_done", 64'(cmd_done_event), 64'd1);
    snap = n_start;
    repeat (5) tick();
    check("t8_quiet", 64'({busy, 8'(n_start - snap)}), 64'd0);

    check("tot_ack", 64'(n_ack), 64'd8);
`ifdef SDIO_AUTO_STOP_EN
    check("tot_start", 64'(n_start), 64'd9);
    check("tot_done", 64'(n_done), 64'd6);
`else
    check("tot_start", 64'(n_start), 64'd8);
    check("tot_done", 64'(n_done), 64'd5);
`endif
    check("tot_tout", 64'({n_tout[7:0], n_abort[7:0]}), 64'h0202);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
